// File: rtl/rf_multiport_sb_pkg.sv
// Shared constants and helpers for the rf_multiport_sb register file and its scoreboard.
// Default geometry and the hardwired-zero register index live here for all rf files.
package rf_multiport_sb_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_NRD  = 2;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cntStepT;

    // One busy bit can rise and a different one can fall on the same edge; they cancel.
    function automatic cntStepT cntStep(input logic inc, input logic dec);
        if (inc && !dec) begin
            return CNT_INC;
        end
        if (dec && !inc) begin
            return CNT_DEC;
        end
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits, busy-register counter and sticky double-reserve error flag.
// State updates on the falling clock edge; reset is asynchronous, active-low.
module rf_scoreboard
    import rf_multiport_sb_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            wrEn,
    input  logic [AW-1:0]   wrAddr,
    input  logic            rsvEn,
    input  logic [AW-1:0]   rsvAddr,
    output logic [NREG-1:0] busyVec,
    output logic [AW:0]     busyCnt,
    output logic            sbErr
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW:0]   CNT_MAX   = (AW+1)'(NREG-1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

    logic            doWr;
    logic            doRsv;
    logic            sameReg;
    logic            incCnt;
    logic            decCnt;
    logic            errSet;
    logic [NREG-1:0] busyNext;
    cntStepT         step;

    assign doWr    = wrEn  && (wrAddr  != ZERO_ADDR);
    assign doRsv   = rsvEn && (rsvAddr != ZERO_ADDR);
    assign sameReg = doWr && doRsv && (wrAddr == rsvAddr);

    // A write that coincides with a reserve of the same register leaves it busy for the new producer.
    assign incCnt = doRsv && !busyVec[rsvAddr];
    assign decCnt = doWr && busyVec[wrAddr] && !sameReg;
    assign errSet = doRsv && busyVec[rsvAddr] && !sameReg;
    assign step   = cntStep(incCnt, decCnt);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : gBusy
            assign busyNext[gi] = (doRsv && (rsvAddr == AW'(gi))) ? 1'b1 :
                                  (doWr  && (wrAddr  == AW'(gi))) ? 1'b0 :
                                  busyVec[gi];
        end
    endgenerate

    always_ff @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            busyVec <= '0;
            busyCnt <= '0;
            sbErr   <= 1'b0;
        end else begin
            busyVec <= busyNext;
            case (step)
                CNT_INC: if (busyCnt != CNT_MAX) busyCnt <= busyCnt + CNT_ONE;
                CNT_DEC: if (busyCnt != '0)      busyCnt <= busyCnt - CNT_ONE;
                default: ;
            endcase
            if (errSet) begin
                sbErr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port register file with hardwired-zero r0 and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward the in-flight write to matching read ports combinationally.
module rf_multiport_sb
    import rf_multiport_sb_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW,
    parameter int NRD  = DEF_NRD
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*DW-1:0] BusA,
    output logic [NRD-1:0]    BusyA,
    input  logic [AW-1:0]     RW,
    input  logic [DW-1:0]     BusW,
    input  logic              RegWr,
    input  logic              Reserve,
    input  logic [AW-1:0]     RR,
    output logic [AW:0]       BusyCnt,
    output logic              SbErr
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [DW-1:0]   regFile [NREG];
    logic [NREG-1:0] busyVec;
    logic            doWr;

    assign doWr = RegWr && (RW != ZERO_ADDR);

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) uScoreboard (
        .clk     (Clk),
        .rstN    (Rst_n),
        .wrEn    (RegWr),
        .wrAddr  (RW),
        .rsvEn   (Reserve),
        .rsvAddr (RR),
        .busyVec (busyVec),
        .busyCnt (BusyCnt),
        .sbErr   (SbErr)
    );

    // Falling-edge write gives the second half of the cycle to readers.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
        end else if (doWr) begin
            regFile[RW] <= BusW;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : gRead
            logic [AW-1:0] rdAddr;
            logic [DW-1:0] storedData;
            logic          storedBusy;

            assign rdAddr     = RA[gi*AW +: AW];
            assign storedData = (rdAddr == ZERO_ADDR) ? '0 : regFile[rdAddr];
            assign storedBusy = busyVec[rdAddr];

`ifdef RF_BYPASS_EN
            logic fwdHit;
            assign fwdHit             = doWr && (rdAddr == RW);
            assign BusA[gi*DW +: DW]  = fwdHit ? BusW : storedData;
            assign BusyA[gi]          = fwdHit ? 1'b0 : storedBusy;
`else
            assign BusA[gi*DW +: DW]  = storedData;
            assign BusyA[gi]          = storedBusy;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed scoreboard bench for rf_multiport_sb (default geometry, 2 read ports).
// Expectations are queued by the stimulus and checked by a separate monitor process.
module tb_rf_multiport_sb;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic              Clk     = 1'b1;
    logic              Rst_n   = 1'b1;
    logic [NRD*AW-1:0] RA      = '0;
    logic [NRD*DW-1:0] BusA;
    logic [NRD-1:0]    BusyA;
    logic [AW-1:0]     RW      = '0;
    logic [DW-1:0]     BusW    = '0;
    logic              RegWr   = 1'b0;
    logic              Reserve = 1'b0;
    logic [AW-1:0]     RR      = '0;
    logic [AW:0]       BusyCnt;
    logic              SbErr;

    rf_multiport_sb #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .RA      (RA),
        .BusA    (BusA),
        .BusyA   (BusyA),
        .RW      (RW),
        .BusW    (BusW),
        .RegWr   (RegWr),
        .Reserve (Reserve),
        .RR      (RR),
        .BusyCnt (BusyCnt),
        .SbErr   (SbErr)
    );

    initial forever #10 Clk = ~Clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [1:0]    busy;
        logic [AW:0]   cnt;
        logic          err;
    } expT;

    expT  expQ[$];
    event sampleEv;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", tag, field, act, req);
        end
    endtask

    // Monitor: pops one expectation per sample strobe and compares all outputs.
    initial begin
        expT e;
        forever begin
            @(sampleEv);
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor sample with empty expectation queue");
            end else begin
                e = expQ.pop_front();
                chk(e.tag, "busA0", BusA[DW-1:0], e.a0);
                chk(e.tag, "busA1", BusA[2*DW-1:DW], e.a1);
                chk(e.tag, "busyA", 32'(BusyA), 32'(e.busy));
                chk(e.tag, "busyCnt", 32'(BusyCnt), 32'(e.cnt));
                chk(e.tag, "sbErr", 32'(SbErr), 32'(e.err));
                $display("check %-16s busA=%h,%h busyA=%b cnt=%0d err=%b",
                         e.tag, BusA[DW-1:0], BusA[2*DW-1:DW], BusyA, BusyCnt, SbErr);
            end
        end
    end

    task automatic expectNow(input string tag, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                             input logic b0, input logic b1, input int cnt, input logic err);
        expT e;
        e.tag  = tag;
        e.a0   = a0;
        e.a1   = a1;
        e.busy = {b1, b0};
        e.cnt  = (AW+1)'(cnt);
        e.err  = err;
        expQ.push_back(e);
        #1;
        -> sampleEv;
        #1;
    endtask

    task automatic setRead(input int a0, input int a1);
        RA[AW-1:0]    = AW'(a0);
        RA[2*AW-1:AW] = AW'(a1);
    endtask

    // Drive one cycle of write/reserve controls, let the falling edge act, then go idle.
    task automatic cycle(input logic wr, input int rw, input logic [DW-1:0] w, input logic rsv, input int rr);
        RegWr   = wr;
        RW      = AW'(rw);
        BusW    = w;
        Reserve = rsv;
        RR      = AW'(rr);
        @(negedge Clk);
        #2;
        RegWr   = 1'b0;
        Reserve = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        Rst_n = 1'b0;
        setRead(1, 0);
        expectNow("reset", 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        Rst_n = 1'b1;

        // Fill r1..r31 with their index; r0 stays zero
        for (int i = 1; i < NREG; i++) begin
            cycle(1'b1, i, 32'(i), 1'b0, 0);
        end
        setRead(5, 6);
        expectNow("wr_r5_r6", 32'd5, 32'd6, 1'b0, 1'b0, 0, 1'b0);
        setRead(31, 1);
        expectNow("wr_r31", 32'd31, 32'd1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 0, 32'h1234_5678, 1'b0, 0);
        setRead(0, 5);
        expectNow("wr_r0", 32'h0, 32'd5, 1'b0, 1'b0, 0, 1'b0);

        // Reserve then retire r7; reserve of r0 is ignored
        cycle(1'b0, 0, 32'h0, 1'b1, 7);
        setRead(7, 0);
        expectNow("rsv_r7", 32'd7, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        cycle(1'b1, 7, 32'hAA, 1'b0, 0);
        expectNow("wr_r7", 32'hAA, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 32'h0, 1'b1, 0);
        expectNow("rsv_r0", 32'hAA, 32'h0, 1'b0, 1'b0, 0, 1'b0);

        // Same-edge write + reserve on a busy register: new producer keeps it busy
        cycle(1'b0, 0, 32'h0, 1'b1, 3);
        setRead(3, 7);
        expectNow("rsv_r3", 32'd3, 32'hAA, 1'b1, 1'b0, 1, 1'b0);
        cycle(1'b1, 3, 32'h33, 1'b1, 3);
        expectNow("wr_rsv_r3", 32'h33, 32'hAA, 1'b1, 1'b0, 1, 1'b0);
        cycle(1'b1, 3, 32'h34, 1'b0, 0);
        expectNow("wr_r3", 32'h34, 32'hAA, 1'b0, 1'b0, 0, 1'b0);

        // Write to idle r3 while reserving r12, then a retire and a new reserve that cancel
        cycle(1'b1, 3, 32'h35, 1'b1, 12);
        setRead(3, 12);
        expectNow("wr3_rsv12", 32'h35, 32'd12, 1'b0, 1'b1, 1, 1'b0);
        cycle(1'b1, 12, 32'hC0, 1'b1, 13);
        setRead(12, 13);
        expectNow("wr12_rsv13", 32'hC0, 32'd13, 1'b0, 1'b1, 1, 1'b0);
        cycle(1'b1, 13, 32'hD0, 1'b0, 0);
        expectNow("wr_r13", 32'hC0, 32'hD0, 1'b0, 1'b0, 0, 1'b0);

        // Double reserve sets the sticky error
        cycle(1'b0, 0, 32'h0, 1'b1, 9);
        setRead(9, 0);
        expectNow("rsv_r9", 32'd9, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        cycle(1'b0, 0, 32'h0, 1'b1, 9);
        expectNow("rsv_r9_again", 32'd9, 32'h0, 1'b1, 1'b0, 1, 1'b1);

        // Forwarding check: sample before and after the falling edge
        cycle(1'b0, 0, 32'h0, 1'b1, 4);
        setRead(4, 9);
        expectNow("rsv_r4", 32'd4, 32'd9, 1'b1, 1'b1, 2, 1'b1);
        RegWr = 1'b1;
        RW    = AW'(4);
        BusW  = 32'hDEAD;
`ifdef RF_BYPASS_EN
        expectNow("fwd_pre", 32'hDEAD, 32'd9, 1'b0, 1'b1, 2, 1'b1);
`else
        expectNow("fwd_pre", 32'd4, 32'd9, 1'b1, 1'b1, 2, 1'b1);
`endif
        @(negedge Clk);
        #2;
        RegWr = 1'b0;
        expectNow("fwd_post", 32'hDEAD, 32'd9, 1'b0, 1'b1, 1, 1'b1);

        // Reset pulse in the high phase clears everything immediately
        cycle(1'b0, 0, 32'h0, 1'b1, 10);
        cycle(1'b0, 0, 32'h0, 1'b1, 11);
        setRead(10, 11);
        expectNow("rsv_r10_r11", 32'd10, 32'd11, 1'b1, 1'b1, 3, 1'b1);
        @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        expectNow("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        setRead(31, 4);
        expectNow("rst_mid_r31", 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        Rst_n = 1'b1;
        cycle(1'b0, 0, 32'h0, 1'b0, 0);
        expectNow("rst_post_edge", 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 2, 32'h22, 1'b0, 0);
        setRead(2, 9);
        expectNow("wr_after_rst", 32'h22, 32'h0, 1'b0, 1'b0, 0, 1'b0);

        #5;
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover expectations actual=%0d required=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
